rf_row_mover: RTL and testbench

RF_ROW_MOVER -- requirements
Module: rf_row_mover

---
 rtl/rf_row_mover.sv | 81 ++++++++
 tb/tb_rf_row_mover.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rf_row_mover.sv
// rf_row_mover: copies runs of register-file rows, one read and one write per row
module rf_row_mover #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 1408
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              cmd_src_inc,
  input  logic              cmd_dst_inc,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_d,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_q
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, src_q, src_d, dst_q, dst_d;
  logic src_inc_q, src_inc_d, dst_inc_q, dst_inc_d;
  // next-state and address/count update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    dst_d     = dst_q;
    src_inc_d = src_inc_q;
    dst_inc_d = dst_inc_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        src_d     = cmd_src;
        dst_d     = cmd_dst;
        cnt_d     = cmd_len;
        src_inc_d = cmd_src_inc;
        dst_inc_d = cmd_dst_inc;
        state_d   = (cmd_len == '0) ? DONE : RD;
      end
      RD: state_d = abort ? DONE : WR;
      WR: begin
        cnt_d   = cnt_q - ADDR_W'(1);
        src_d   = src_q + ADDR_W'(src_inc_q);
        dst_d   = dst_q + ADDR_W'(dst_inc_q);
        state_d = (abort || cnt_q <= ADDR_W'(1)) ? DONE : RD;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      src_inc_q <= src_inc_d;
      dst_inc_q <= dst_inc_d;
    end
  end
  // outputs decoded from the registered state; rf_d forwards the row read in RD
  always_comb begin
    cmd_ready = rst_n && state_q == IDLE;
    busy      = state_q != IDLE;
    done      = state_q == DONE;
    rf_we     = state_q == WR;
    rf_addr   = (state_q == RD) ? src_q : (state_q == WR) ? dst_q : '0;
    rf_d      = (state_q == WR) ? rf_q : '0;
  end
endmodule

// File: tb/tb_rf_row_mover.sv
// tb_rf_row_mover: directed checks of rf_row_mover against a behavioural register file
module tb_rf_row_mover;
  localparam int DW = 1408;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, abort = 1'b0;
  logic cmd_src_inc = 1'b0, cmd_dst_inc = 1'b0;
  logic [8:0] cmd_src = '0, cmd_dst = '0, cmd_len = '0;
  logic cmd_ready, busy, done, rf_we;
  logic [8:0] rf_addr;
  logic [DW-1:0] rf_d, rf_q;
  int tests = 0, fails = 0, cyc = 0, viol = 0;
  typedef struct {int t; logic [8:0] a; logic [DW-1:0] d;} ev_t;
  ev_t wr_q[$], rd_q[$];
  int done_q[$], acc_q[$];
  logic [DW-1:0] mem [512];
  bit wv [512];

  rf_row_mover dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_src_inc(cmd_src_inc), .cmd_dst_inc(cmd_dst_inc), .abort(abort),
    .busy(busy), .done(done), .rf_addr(rf_addr), .rf_d(rf_d), .rf_we(rf_we), .rf_q(rf_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input logic [8:0] a);
    logic [31:0] w;
    w = {8'hC3, 15'(a) * 15'd37 ^ 15'h2A5A, a};
    return {(DW/32){w}} ^ {{(DW-32){1'b0}}, 32'(a)};
  endfunction

  function automatic logic [DW-1:0] row(input logic [8:0] a);
    return wv[a] ? mem[a] : pat(a);
  endfunction

  always @(posedge clk) begin
    rf_q <= row(rf_addr);
    if (rf_we === 1'b1) begin
      mem[rf_addr] <= rf_d;
      wv[rf_addr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rf_we === 1'b1) wr_q.push_back('{cyc + 1, rf_addr, rf_d});
    if (busy === 1'b1 && rf_we === 1'b0 && done === 1'b0) rd_q.push_back('{cyc + 1, rf_addr, '0});
    if (done === 1'b1) done_q.push_back(cyc + 1);
    if (cmd_valid && cmd_ready === 1'b1) acc_q.push_back(cyc + 1);
    if ((rf_we === 1'b0 && rf_d != '0) || (busy === 1'b0 && rf_addr != '0) ||
        (done === 1'b1 && (rf_addr != '0 || busy !== 1'b1))) viol++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    wr_q.delete(); rd_q.delete(); done_q.delete(); acc_q.delete();
  endtask

  task automatic issue(input logic [8:0] s, d, l, input logic si, di, output int t);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("issue_ready_wait", 64'(n < 100), 1);
    cmd_src = s; cmd_dst = d; cmd_len = l; cmd_src_inc = si; cmd_dst_inc = di;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_wait", 64'(n < 200), 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int t, t2;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_ready_low", 64'(cmd_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(cmd_ready), 1);
    chk("post_rst_busy", 64'(busy), 0);
    chk("post_rst_done", 64'(done), 0);
    chk("post_rst_we", 64'(rf_we), 0);
    chk("post_rst_addr", 64'(rf_addr), 0);
    chk("post_rst_d_zero", 64'(rf_d == '0), 1);

    clr();
    issue(9'h010, 9'h020, 9'd3, 1'b1, 1'b1, t);
    wait_idle();
    chk("copy3_nwr", 64'(wr_q.size()), 3);
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      chk($sformatf("copy3_t%0d", i), 64'(wr_q[i].t - t), 64'(2 + 2 * i));
      chk($sformatf("copy3_a%0d", i), 64'(wr_q[i].a), 64'(9'h020 + i));
      chk($sformatf("copy3_d%0d", i), 64'(wr_q[i].d == pat(9'(9'h010 + i))), 1);
    end
    chk("copy3_ndone", 64'(done_q.size()), 1);
    if (done_q.size() > 0) chk("copy3_done_t", 64'(done_q[0] - t), 7);

    clr();
    issue(9'h040, 9'h100, 9'd4, 1'b1, 1'b0, t);
    wait_idle();
    chk("stream_nwr", 64'(wr_q.size()), 4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      chk($sformatf("stream_a%0d", i), 64'(wr_q[i].a), 64'h100);
      chk($sformatf("stream_d%0d", i), 64'(wr_q[i].d == pat(9'(9'h040 + i))), 1);
    end

    clr();
    issue(9'h1FE, 9'h0FE, 9'd3, 1'b1, 1'b1, t);
    wait_idle();
    chk("wrap_nrd", 64'(rd_q.size()), 3);
    chk("wrap_nwr", 64'(wr_q.size()), 3);
    for (int i = 0; i < 3 && i < rd_q.size() && i < wr_q.size(); i++) begin
      chk($sformatf("wrap_src%0d", i), 64'(rd_q[i].a), 64'(9'(9'h1FE + i)));
      chk($sformatf("wrap_dst%0d", i), 64'(wr_q[i].a), 64'(9'(9'h0FE + i)));
      chk($sformatf("wrap_d%0d", i), 64'(wr_q[i].d == pat(9'(9'h1FE + i))), 1);
    end

    clr();
    issue(9'h005, 9'h006, 9'd0, 1'b1, 1'b1, t);
    chk("len0_done", 64'(done), 1);
    chk("len0_ready_in_done", 64'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("len0_ready_again", 64'(cmd_ready), 1);
    chk("len0_done_clear", 64'(done), 0);
    wait_idle();
    chk("len0_nwr", 64'(wr_q.size()), 0);
    chk("len0_ndone", 64'(done_q.size()), 1);

    clr();
    issue(9'h060, 9'h080, 9'd8, 1'b1, 1'b1, t);
    cmd_src = 9'h070; cmd_dst = 9'h090; cmd_len = 9'd2; cmd_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    for (int n = 0; n < 50 && acc_q.size() < 2; n++) begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    wait_idle();
    chk("abort_nacc", 64'(acc_q.size()), 2);
    t2 = acc_q.size() > 1 ? acc_q[1] : 0;
    chk("abort_b2b_gap", 64'(t2 - t), 6);
    chk("abort_nwr", 64'(wr_q.size()), 4);
    if (wr_q.size() == 4) begin
      chk("abort_t0", 64'(wr_q[0].t - t), 2);
      chk("abort_t1", 64'(wr_q[1].t - t), 4);
      chk("abort_a1", 64'(wr_q[1].a), 64'h081);
      chk("abort_d1", 64'(wr_q[1].d == pat(9'h061)), 1);
      chk("b2b_a0", 64'(wr_q[2].a), 64'h090);
      chk("b2b_a1", 64'(wr_q[3].a), 64'h091);
      chk("b2b_d1", 64'(wr_q[3].d == pat(9'h071)), 1);
    end
    chk("abort_ndone", 64'(done_q.size()), 2);
    if (done_q.size() == 2) begin
      chk("abort_done_t", 64'(done_q[0] - t), 5);
      chk("b2b_done_t", 64'(done_q[1] - t2), 5);
    end

    clr();
    issue(9'h0A0, 9'h0C0, 9'd8, 1'b1, 1'b1, t);
    repeat (10) begin @(posedge clk); #1; end
    chk("midrst_in_rd", 64'(rf_addr), 64'h0A5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_we", 64'(rf_we), 0);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_ready_low", 64'(cmd_ready), 0);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_ndone", 64'(done_q.size()), 0);
    chk("midrst_nwr", 64'(wr_q.size()), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("midrst_row%0d", i), 64'(row(9'(9'h0C0 + i)) == pat(9'(9'h0A0 + i))), 1);
    chk("midrst_row5_untouched", 64'(wv[9'h0C5]), 0);
    chk("idle_outputs_clean", 64'(viol), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
